// File: rtl/axi_dma_arbiter.sv
// axi_dma_arbiter: shares one axi_dma transfer engine between C_NUM_REQ
// requesters. One descriptor is granted, latched, issued to the DMA and
// completed with a one-cycle done/error pulse back to its owner.
// Optional build macro AXI_DMA_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins); when undefined the grant is round-robin.
module axi_dma_arbiter #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_AXI_ADDR_WIDTH_H = 64,
  parameter int C_AXI_ADDR_WIDTH_F = 32,
  parameter int C_LEN_WIDTH        = 24,
  localparam int PW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [C_NUM_REQ-1:0]                    req_valid,
  output logic [C_NUM_REQ-1:0]                    req_ready,
  input  logic [C_NUM_REQ-1:0]                    req_dir,
  input  logic [C_NUM_REQ*C_AXI_ADDR_WIDTH_H-1:0] req_host_addr,
  input  logic [C_NUM_REQ*C_AXI_ADDR_WIDTH_F-1:0] req_fpga_addr,
  input  logic [C_NUM_REQ*C_LEN_WIDTH-1:0]        req_len,
  output logic [C_NUM_REQ-1:0]                    done_valid,
  output logic [C_NUM_REQ-1:0]                    done_error,
  output logic                                    cmd_valid,
  input  logic                                    cmd_ready,
  output logic                                    cmd_dir,
  output logic [C_AXI_ADDR_WIDTH_H-1:0]           cmd_host_addr,
  output logic [C_AXI_ADDR_WIDTH_F-1:0]           cmd_fpga_addr,
  output logic [C_LEN_WIDTH-1:0]                  cmd_len,
  input  logic                                    cmd_done,
  input  logic                                    cmd_error,
  output logic                                    busy,
  output logic [PW-1:0]                           owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                        r_state;
  logic [PW-1:0]                 r_owner;
  logic                          r_error;
  logic                          r_busy;
  logic                          r_cmd_valid;
  logic                          r_cmd_dir;
  logic [C_AXI_ADDR_WIDTH_H-1:0] r_cmd_host_addr;
  logic [C_AXI_ADDR_WIDTH_F-1:0] r_cmd_fpga_addr;
  logic [C_LEN_WIDTH-1:0]        r_cmd_len;
  logic [C_NUM_REQ-1:0]          r_done_valid;
  logic [C_NUM_REQ-1:0]          r_done_error;

  logic [PW-1:0]                 w_grant;
  logic                          w_found;
  logic                          w_handshake;
  logic [C_LEN_WIDTH-1:0]        w_sel_len;

`ifdef AXI_DMA_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downwards so the lowest valid index is the last write.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant = PW'(i);
        w_found = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_idx;

  // Round-robin: first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      w_idx = PW'((int'(r_rr_ptr) + i) % C_NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the winner so it gets lowest priority next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_handshake) begin
      r_rr_ptr <= (int'(w_grant) == C_NUM_REQ - 1) ? '0 : PW'(int'(w_grant) + 1);
    end
  end
`endif

  assign w_handshake = (r_state == IDLE) && w_found;
  assign w_sel_len   = req_len[int'(w_grant)*C_LEN_WIDTH +: C_LEN_WIDTH];

  // Ready goes only to the winner, only in IDLE, and is forced low during reset.
  always_comb begin
    req_ready = '0;
    if (w_handshake && !rst) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Sequencer: grant/latch, issue to DMA, wait for completion, pulse the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_owner         <= '0;
      r_error         <= 1'b0;
      r_busy          <= 1'b0;
      r_cmd_valid     <= 1'b0;
      r_cmd_dir       <= 1'b0;
      r_cmd_host_addr <= '0;
      r_cmd_fpga_addr <= '0;
      r_cmd_len       <= '0;
      r_done_valid    <= '0;
      r_done_error    <= '0;
    end else begin
      r_done_valid <= '0;
      r_done_error <= '0;
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_owner         <= w_grant;
            r_busy          <= 1'b1;
            r_cmd_dir       <= req_dir[w_grant];
            r_cmd_host_addr <= req_host_addr[int'(w_grant)*C_AXI_ADDR_WIDTH_H +: C_AXI_ADDR_WIDTH_H];
            r_cmd_fpga_addr <= req_fpga_addr[int'(w_grant)*C_AXI_ADDR_WIDTH_F +: C_AXI_ADDR_WIDTH_F];
            r_cmd_len       <= w_sel_len;
            if (w_sel_len != '0) begin
              r_state     <= ISSUE;
              r_cmd_valid <= 1'b1;
              r_error     <= 1'b0;
            end else begin
              r_state               <= RESP;
              r_error               <= 1'b1;
              r_done_valid[w_grant] <= 1'b1;
              r_done_error[w_grant] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            r_error               <= cmd_error;
            r_done_valid[r_owner] <= 1'b1;
            r_done_error[r_owner] <= cmd_error;
            r_state               <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_dir       = r_cmd_dir;
  assign cmd_host_addr = r_cmd_host_addr;
  assign cmd_fpga_addr = r_cmd_fpga_addr;
  assign cmd_len       = r_cmd_len;
  assign done_valid    = r_done_valid;
  assign done_error    = r_done_error;
  assign busy          = r_busy;
  assign owner         = r_owner;

endmodule

// File: tb/tb_axi_dma_arbiter.sv
// Directed testbench for axi_dma_arbiter (4 requesters). Inputs are driven
// 1 ns after the rising edge and outputs are checked 1 ns later.
module tb_axi_dma_arbiter;

  localparam int N  = 4;
  localparam int HW = 64;
  localparam int FW = 32;
  localparam int LW = 24;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_dir;
  logic [N*HW-1:0]   req_host_addr;
  logic [N*FW-1:0]   req_fpga_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      done_valid;
  logic [N-1:0]      done_error;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [HW-1:0]     cmd_host_addr;
  logic [FW-1:0]     cmd_fpga_addr;
  logic [LW-1:0]     cmd_len;
  logic              cmd_done;
  logic              cmd_error;
  logic              busy;
  logic [1:0]        owner;

  logic [HW-1:0]     hostA [N];
  logic [FW-1:0]     fpgaA [N];
  logic [LW-1:0]     lenA  [N];
  logic              dirA  [N];

  int assertCount = 0;
  int failCount   = 0;

  axi_dma_arbiter #(
    .C_NUM_REQ(N), .C_AXI_ADDR_WIDTH_H(HW), .C_AXI_ADDR_WIDTH_F(FW), .C_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_host_addr(req_host_addr), .req_fpga_addr(req_fpga_addr), .req_len(req_len),
    .done_valid(done_valid), .done_error(done_error),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_host_addr(cmd_host_addr), .cmd_fpga_addr(cmd_fpga_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .cmd_error(cmd_error),
    .busy(busy), .owner(owner)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-requester descriptor tables into the flattened buses.
  always_comb begin
    req_host_addr = '0;
    req_fpga_addr = '0;
    req_len       = '0;
    req_dir       = '0;
    for (int i = 0; i < N; i++) begin
      req_host_addr[i*HW +: HW] = hostA[i];
      req_fpga_addr[i*FW +: FW] = fpgaA[i];
      req_len[i*LW +: LW]       = lenA[i];
      req_dir[i]                = dirA[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic rdy, input logic done, input logic err);
    @(posedge clk);
    #1;
    req_valid = valid;
    cmd_ready = rdy;
    cmd_done  = done;
    cmd_error = err;
    #1;
  endtask

  // One full transfer with the given valid pattern held throughout.
  task automatic doTransfer(input logic [N-1:0] valid, input int expIdx, input logic err, input string tag);
    logic [N-1:0] oh;
    oh = 4'(1) << expIdx;
    applyStimulus(valid, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " grant"}, 64'(req_ready), 64'(oh));
    applyStimulus(valid, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " cmd_valid"}, 64'(cmd_valid), 64'd1);
    checkOutput({tag, " owner"}, 64'(owner), 64'(expIdx));
    checkOutput({tag, " cmd_len"}, 64'(cmd_len), 64'(lenA[expIdx]));
    checkOutput({tag, " cmd_host"}, cmd_host_addr, hostA[expIdx]);
    applyStimulus(valid, 1'b0, 1'b1, err);
    checkOutput({tag, " wait cmd_valid"}, 64'(cmd_valid), 64'd0);
    checkOutput({tag, " wait done_valid"}, 64'(done_valid), 64'd0);
    applyStimulus(valid, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " done_valid"}, 64'(done_valid), 64'(oh));
    checkOutput({tag, " done_error"}, 64'(done_error), err ? 64'(oh) : 64'd0);
    checkOutput({tag, " resp busy"}, 64'(busy), 64'd1);
  endtask

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int rrOrder [5];
    hostA[0] = 64'h0000_0000_8000_0000; fpgaA[0] = 32'h0000_1000; lenA[0] = 24'd64;   dirA[0] = 1'b0;
    hostA[1] = 64'h0000_0002_0000_0040; fpgaA[1] = 32'h0000_2000; lenA[1] = 24'd128;  dirA[1] = 1'b1;
    hostA[2] = 64'h0000_0001_0000_0000; fpgaA[2] = 32'h0000_4000; lenA[2] = 24'd256;  dirA[2] = 1'b1;
    hostA[3] = 64'h0000_0003_1234_5600; fpgaA[3] = 32'h0000_8000; lenA[3] = 24'd1024; dirA[3] = 1'b0;
`ifdef AXI_DMA_ARB_FIXED_PRIO_EN
    rrOrder = '{0, 0, 0, 0, 0};
`else
    rrOrder = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1; req_valid = '0; cmd_ready = 1'b0; cmd_done = 1'b0; cmd_error = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset owner", 64'(owner), 64'd0);
    checkOutput("reset done_valid", 64'(done_valid), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single request from requester 2.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("single ready", 64'(req_ready), 64'h4);
    checkOutput("single busy T", 64'(busy), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single cmd_valid T+1", 64'(cmd_valid), 64'd1);
    checkOutput("single cmd_dir", 64'(cmd_dir), 64'd1);
    checkOutput("single cmd_host", cmd_host_addr, 64'h0000_0001_0000_0000);
    checkOutput("single cmd_fpga", 64'(cmd_fpga_addr), 64'h4000);
    checkOutput("single cmd_len", 64'(cmd_len), 64'd256);
    checkOutput("single owner", 64'(owner), 64'd2);
    checkOutput("single busy T+1", 64'(busy), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single cmd_valid T+2", 64'(cmd_valid), 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("single cmd_valid T+3", 64'(cmd_valid), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single cmd_valid T+4", 64'(cmd_valid), 64'd0);
    repeat (5) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single done_valid T+11", 64'(done_valid), 64'h4);
    checkOutput("single done_error T+11", 64'(done_error), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("single busy T+12", 64'(busy), 64'd0);
    checkOutput("single done_valid T+12", 64'(done_valid), 64'h0);

    // Fresh reset so the pointer starts at 0, then all requesters valid.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      doTransfer(4'b1111, rrOrder[k], 1'b0, $sformatf("rr%0d", k));
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Zero-length request from requester 1.
    lenA[1] = 24'd0;
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("zero ready", 64'(req_ready), 64'h2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("zero cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("zero done_valid", 64'(done_valid), 64'h2);
    checkOutput("zero done_error", 64'(done_error), 64'h2);
    checkOutput("zero busy", 64'(busy), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("zero done_valid after", 64'(done_valid), 64'h0);
    checkOutput("zero busy after", 64'(busy), 64'd0);
    checkOutput("zero cmd_valid after", 64'(cmd_valid), 64'd0);
    lenA[1] = 24'd128;

    // DMA error reported for owner 3.
    doTransfer(4'b1000, 3, 1'b1, "err3");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("err3 done_valid after", 64'(done_valid), 64'h0);
    checkOutput("err3 done_error after", 64'(done_error), 64'h0);

    // Back-pressure with a spurious completion during ISSUE.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("bp ready", 64'(req_ready), 64'h1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b1111, 1'b0, (k == 5), 1'b0);
      checkOutput($sformatf("bp cmd_valid %0d", k), 64'(cmd_valid), 64'd1);
      checkOutput($sformatf("bp cmd_host %0d", k), cmd_host_addr, hostA[0]);
      checkOutput($sformatf("bp cmd_len %0d", k), 64'(cmd_len), 64'(lenA[0]));
      checkOutput($sformatf("bp req_ready %0d", k), 64'(req_ready), 64'h0);
    end
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    checkOutput("bp accept cmd_valid", 64'(cmd_valid), 64'd1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("bp wait cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("bp wait done_valid", 64'(done_valid), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("bp done_valid", 64'(done_valid), 64'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset asserted while waiting for completion.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("rstw ready", 64'(req_ready), 64'h4);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    checkOutput("rstw owner", 64'(owner), 64'd2);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("rstw busy before", 64'(busy), 64'd1);
    #2; rst = 1'b1; #1;
    checkOutput("rstw cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("rstw busy", 64'(busy), 64'd0);
    checkOutput("rstw owner0", 64'(owner), 64'd0);
    checkOutput("rstw cmd_len", 64'(cmd_len), 64'd0);
    checkOutput("rstw cmd_host", cmd_host_addr, 64'd0);
    checkOutput("rstw done_valid", 64'(done_valid), 64'h0);
    checkOutput("rstw req_ready", 64'(req_ready), 64'h0);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
    checkOutput("rstw done during rst", 64'(done_valid), 64'h0);
    @(posedge clk); #1; rst = 1'b0; cmd_done = 1'b0; #1;
    checkOutput("rstw first grant", 64'(req_ready), 64'h1);
    checkOutput("rstw no pulse", 64'(done_valid), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("rstw new owner", 64'(owner), 64'd0);
    checkOutput("rstw new cmd_valid", 64'(cmd_valid), 64'd1);
    checkOutput("rstw new done_valid", 64'(done_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
